// File: rtl/updown_counter_rpt.sv
// updown_counter_rpt
//   Up/down counter driven by two raw push-buttons. Each button goes through
//   a 2-flop synchroniser, a glitch-rejecting debouncer (DB_CYC cycles on both
//   press and release) and an optional hold-to-repeat engine. Accepted steps
//   are shown as 1-cycle pulses and applied to the count on the following edge.
//
// Ports
//   clk      in   1      system clock
//   rstn     in   1      asynchronous reset, active low
//   up_in    in   1      raw up button, active high, asynchronous, may bounce
//   down_in  in   1      raw down button, same properties as up_in
//   clr      in   1      synchronous clear to INIT, overrides steps this cycle
//   count    out  WIDTH  registered counter value
//   step_up  out  1      1-cycle pulse: up step accepted
//   step_dn  out  1      1-cycle pulse: down step accepted
//   at_max   out  1      count == 2^WIDTH-1
//   at_min   out  1      count == 0
module updown_counter_rpt #(
  parameter int WIDTH       = 8,
  parameter int INIT        = 8,
  parameter int DB_CYC      = 32768,
  parameter int RPT_EN      = 1,
  parameter int RPT_DLY_CYC = 6000000,
  parameter int RPT_PER_CYC = 1200000,
  parameter int SATURATE    = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             up_in,
  input  logic             down_in,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             step_up,
  output logic             step_dn,
  output logic             at_max,
  output logic             at_min
);

  // Timer only ever has to reach the largest terminal count minus one.
  localparam int MAX_AB = (DB_CYC > RPT_DLY_CYC) ? DB_CYC : RPT_DLY_CYC;
  localparam int MAX_TC = (MAX_AB > RPT_PER_CYC) ? MAX_AB : RPT_PER_CYC;
  localparam int TW     = $clog2(MAX_TC);

  localparam logic [TW-1:0]    DB_TC  = TW'(DB_CYC - 1);
  localparam logic [TW-1:0]    DLY_TC = TW'(RPT_DLY_CYC - 1);
  localparam logic [TW-1:0]    PER_TC = TW'(RPT_PER_CYC - 1);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] MAX_V  = '1;
  localparam logic [WIDTH-1:0] MIN_V  = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_1,
    S_PULSE_1,
    S_HOLD_DLY,
    S_PULSE_N,
    S_HOLD_RPT,
    S_HOLD,
    S_WAIT_0
  } btn_state_e;

  logic [1:0] raw;
  logic [1:0] step_w;

  assign raw = {down_in, up_in};

  // Channel 0 = up button, channel 1 = down button.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          sync1_q, sync2_q;
    btn_state_e    state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic          step_q, step_d;

    always_comb begin
      state_d = state_q;
      t_d     = t_q;
      step_d  = 1'b0;
      case (state_q)
        S_IDLE:     if (sync2_q) state_d = S_WAIT_1;
        S_WAIT_1: begin
          if (!sync2_q)          state_d = S_IDLE;
          else if (t_q == DB_TC) state_d = S_PULSE_1;
        end
        S_PULSE_1:  state_d = (RPT_EN != 0) ? S_HOLD_DLY : S_HOLD;
        // Release is checked before the terminal count in every hold state.
        S_HOLD_DLY: begin
          if (!sync2_q)           state_d = S_WAIT_0;
          else if (t_q == DLY_TC) state_d = S_PULSE_N;
        end
        S_PULSE_N:  state_d = S_HOLD_RPT;
        S_HOLD_RPT: begin
          if (!sync2_q)           state_d = S_WAIT_0;
          else if (t_q == PER_TC) state_d = S_PULSE_N;
        end
        S_HOLD:     if (!sync2_q) state_d = S_WAIT_0;
        S_WAIT_0:   if (!sync2_q && t_q == DB_TC) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase

      // A bounce back high while waiting for release restarts the window.
      if (state_d != state_q || (state_q == S_WAIT_0 && sync2_q)) begin
        t_d = '0;
      end else if (state_q inside {S_WAIT_1, S_HOLD_DLY, S_HOLD_RPT, S_WAIT_0}) begin
        t_d = t_q + TW'(1);
      end

      // Registered step output: high exactly while the FSM sits in a pulse state.
      step_d = (state_d == S_PULSE_1) || (state_d == S_PULSE_N);
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        state_q <= S_IDLE;
        t_q     <= '0;
        step_q  <= 1'b0;
      end else begin
        sync1_q <= raw[gi];
        sync2_q <= sync1_q;
        state_q <= state_d;
        t_q     <= t_d;
        step_q  <= step_d;
      end
    end

    assign step_w[gi] = step_q;
  end

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = INIT_V;
    end else if (step_w[0] && step_w[1]) begin
      count_d = count_q;
    end else if (step_w[0]) begin
      if (!(SATURATE != 0 && count_q == MAX_V)) count_d = count_q + WIDTH'(1);
    end else if (step_w[1]) begin
      if (!(SATURATE != 0 && count_q == MIN_V)) count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= INIT_V;
    else       count_q <= count_d;
  end

  assign count   = count_q;
  assign step_up = step_w[0];
  assign step_dn = step_w[1];
  assign at_max  = (count_q == MAX_V);
  assign at_min  = (count_q == MIN_V);

endmodule

// File: tb/tb_updown_counter_rpt.sv
// tb_updown_counter_rpt
//   Three counters share the same buttons: A (no repeat, wrap), B (repeat,
//   wrap), C (repeat, saturate). A timestamp-based reference model predicts
//   steps and counts every cycle; scenario tasks add directed checks.
module tb_updown_counter_rpt;
  localparam int W    = 4;
  localparam int INIT = 8;
  localparam int DB   = 4;
  localparam int DLY  = 20;
  localparam int PER  = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic up_in = 1'b0, down_in = 1'b0, clr = 1'b0;
  logic [W-1:0] cnt [3];
  logic [2:0] su, sd, amx, amn;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  updown_counter_rpt #(.WIDTH(W), .INIT(INIT), .DB_CYC(DB), .RPT_EN(0),
    .RPT_DLY_CYC(DLY), .RPT_PER_CYC(PER), .SATURATE(0)) dut_a (
    .clk(clk), .rstn(rstn), .up_in(up_in), .down_in(down_in), .clr(clr),
    .count(cnt[0]), .step_up(su[0]), .step_dn(sd[0]), .at_max(amx[0]), .at_min(amn[0]));

  updown_counter_rpt #(.WIDTH(W), .INIT(INIT), .DB_CYC(DB), .RPT_EN(1),
    .RPT_DLY_CYC(DLY), .RPT_PER_CYC(PER), .SATURATE(0)) dut_b (
    .clk(clk), .rstn(rstn), .up_in(up_in), .down_in(down_in), .clr(clr),
    .count(cnt[1]), .step_up(su[1]), .step_dn(sd[1]), .at_max(amx[1]), .at_min(amn[1]));

  updown_counter_rpt #(.WIDTH(W), .INIT(INIT), .DB_CYC(DB), .RPT_EN(1),
    .RPT_DLY_CYC(DLY), .RPT_PER_CYC(PER), .SATURATE(1)) dut_c (
    .clk(clk), .rstn(rstn), .up_in(up_in), .down_in(down_in), .clr(clr),
    .count(cnt[2]), .step_up(su[2]), .step_dn(sd[2]), .at_max(amx[2]), .at_min(amn[2]));

  // ---------------- reference model ----------------
  // Phases: 0 released, 1 press being confirmed, 2 held, 3 release being confirmed.
  int rpt_cfg [3] = '{0, 1, 1};
  int sat_cfg [3] = '{0, 0, 1};
  int ph      [3][2];
  int ref_e   [3][2];
  int nxt_e   [3][2];
  int pulse_e [3][2];
  bit m_step  [3][2];
  int m_count [3];
  bit r1 [2];
  bit r2 [2];
  bit sv [2];
  int me = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      me++;
      if (!rstn) begin
        for (int i = 0; i < 3; i++) begin
          m_count[i] = INIT;
          for (int c = 0; c < 2; c++) begin
            ph[i][c] = 0; m_step[i][c] = 0; ref_e[i][c] = 0; nxt_e[i][c] = -1; pulse_e[i][c] = 0;
          end
        end
        for (int c = 0; c < 2; c++) begin r1[c] = 0; r2[c] = 0; end
      end else begin
        // Button value seen by the debouncer is the raw level from two edges ago.
        for (int c = 0; c < 2; c++) begin
          sv[c] = r2[c];
          r2[c] = r1[c];
          r1[c] = (c == 0) ? up_in : down_in;
        end
        for (int i = 0; i < 3; i++) begin
          if (clr) m_count[i] = INIT;
          else if (m_step[i][0] && m_step[i][1]) m_count[i] = m_count[i];
          else if (m_step[i][0]) m_count[i] = (sat_cfg[i] != 0) ? ((m_count[i] == 15) ? 15 : m_count[i] + 1) : (m_count[i] + 1) % 16;
          else if (m_step[i][1]) m_count[i] = (sat_cfg[i] != 0) ? ((m_count[i] == 0) ? 0 : m_count[i] - 1) : (m_count[i] + 15) % 16;
          for (int c = 0; c < 2; c++) begin
            bit stp;
            stp = 0;
            case (ph[i][c])
              0: if (sv[c]) begin ph[i][c] = 1; ref_e[i][c] = me; end
              1: begin
                if (!sv[c]) ph[i][c] = 0;
                else if (me == ref_e[i][c] + DB) begin
                  stp = 1; ph[i][c] = 2; pulse_e[i][c] = me;
                  nxt_e[i][c] = (rpt_cfg[i] != 0) ? me + DLY + 1 : -1;
                end
              end
              2: begin
                if (me > pulse_e[i][c] + 1 && !sv[c]) begin ph[i][c] = 3; ref_e[i][c] = me; end
                else if (me == nxt_e[i][c]) begin
                  stp = 1; pulse_e[i][c] = me; nxt_e[i][c] = me + PER + 1;
                end
              end
              default: begin
                if (sv[c]) ref_e[i][c] = me;
                else if (me == ref_e[i][c] + DB) ph[i][c] = 0;
              end
            endcase
            m_step[i][c] = stp;
          end
        end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[i] !== 4'(m_count[i])) begin
          errors++; $display("FAIL mon_count[%0d] t=%0t: got %0d expected %0d", i, $time, cnt[i], m_count[i]);
        end
        checks++;
        if (su[i] !== m_step[i][0] || sd[i] !== m_step[i][1]) begin
          errors++; $display("FAIL mon_steps[%0d] t=%0t: got up=%b dn=%b expected up=%b dn=%b", i, $time, su[i], sd[i], m_step[i][0], m_step[i][1]);
        end
        checks++;
        if (amx[i] !== (m_count[i] == 15) || amn[i] !== (m_count[i] == 0)) begin
          errors++; $display("FAIL mon_flags[%0d] t=%0t: got max=%b min=%b for model count %0d", i, $time, amx[i], amn[i], m_count[i]);
        end
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic idle(input int n);
    up_in = 1'b0; down_in = 1'b0; clr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 4'd8) begin errors++; $display("FAIL reset_count[%0d]: got %0d expected 8", i, cnt[i]); end
      checks++;
      if (su[i] !== 1'b0 || sd[i] !== 1'b0) begin errors++; $display("FAIL reset_steps[%0d]: got up=%b dn=%b expected 0 0", i, su[i], sd[i]); end
      checks++;
      if (amx[i] !== 1'b0 || amn[i] !== 1'b0) begin errors++; $display("FAIL reset_flags[%0d]: got max=%b min=%b expected 0 0", i, amx[i], amn[i]); end
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single_press();
    int first, nstep;
    do_clr();
    first = -1; nstep = 0;
    for (int k = 1; k <= 25; k++) begin
      up_in = (k <= 10);
      @(negedge clk);
      if (su[0]) begin nstep++; if (first < 0) first = k; end
      if (k == 7) begin checks++; if (cnt[0] !== 4'd8) begin errors++; $display("FAIL single_cnt_e7: got %0d expected 8", cnt[0]); end end
      if (k == 8) begin checks++; if (cnt[0] !== 4'd9) begin errors++; $display("FAIL single_cnt_e8: got %0d expected 9", cnt[0]); end end
    end
    checks++; if (first != 7) begin errors++; $display("FAIL single_first_step: got edge %0d expected 7", first); end
    checks++; if (nstep != 1) begin errors++; $display("FAIL single_nsteps: got %0d expected 1", nstep); end
    checks++; if (cnt[1] !== 4'd9) begin errors++; $display("FAIL single_cnt_b: got %0d expected 9", cnt[1]); end
    idle(10);
    $display("test_single_press done");
  endtask

  task automatic test_bounce();
    int nstep;
    do_clr();
    nstep = 0;
    for (int k = 1; k <= 32; k++) begin
      up_in = (k <= 12) && (((k - 1) / 2) % 2 == 0);
      @(negedge clk);
      if (su != 3'b000 || sd != 3'b000) nstep++;
    end
    checks++; if (nstep != 0) begin errors++; $display("FAIL bounce_steps: got %0d step cycles expected 0", nstep); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (cnt[i] !== 4'd8) begin errors++; $display("FAIL bounce_cnt[%0d]: got %0d expected 8", i, cnt[i]); end
    end
    $display("test_bounce done");
  endtask

  task automatic test_repeat();
    int eb[$];
    int exp_e[5];
    int na;
    exp_e = '{7, 28, 37, 46, 55};
    na = 0;
    do_clr();
    for (int k = 1; k <= 75; k++) begin
      up_in = (k <= 60);
      @(negedge clk);
      if (su[1]) eb.push_back(k);
      if (su[0]) na++;
    end
    checks++; if (eb.size() != 5) begin errors++; $display("FAIL repeat_nsteps: got %0d expected 5", eb.size()); end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (j >= eb.size() || eb[j] != exp_e[j]) begin
        errors++; $display("FAIL repeat_edge[%0d]: got %0d expected %0d", j, (j < eb.size()) ? eb[j] : -1, exp_e[j]);
      end
    end
    checks++; if (cnt[1] !== 4'd13) begin errors++; $display("FAIL repeat_cnt_b: got %0d expected 13", cnt[1]); end
    checks++; if (cnt[2] !== 4'd13) begin errors++; $display("FAIL repeat_cnt_c: got %0d expected 13", cnt[2]); end
    checks++; if (na != 1 || cnt[0] !== 4'd9) begin errors++; $display("FAIL repeat_norpt_a: got %0d steps count %0d expected 1 and 9", na, cnt[0]); end
    idle(10);
    $display("test_repeat done");
  endtask

  task automatic test_wrap();
    bit seen_c;
    do_clr();
    for (int k = 1; k <= 85; k++) begin up_in = (k <= 73); @(negedge clk); end
    checks++; if (cnt[1] !== 4'd15 || amx[1] !== 1'b1) begin errors++; $display("FAIL wrap_top_b: got %0d max=%b expected 15 1", cnt[1], amx[1]); end
    checks++; if (cnt[2] !== 4'd15 || amx[2] !== 1'b1) begin errors++; $display("FAIL wrap_top_c: got %0d max=%b expected 15 1", cnt[2], amx[2]); end
    seen_c = 0;
    for (int k = 1; k <= 25; k++) begin up_in = (k <= 10); @(negedge clk); if (su[2]) seen_c = 1; end
    checks++; if (cnt[1] !== 4'd0 || amn[1] !== 1'b1) begin errors++; $display("FAIL wrap_up_b: got %0d min=%b expected 0 1", cnt[1], amn[1]); end
    checks++; if (cnt[2] !== 4'd15 || amx[2] !== 1'b1) begin errors++; $display("FAIL sat_up_c: got %0d max=%b expected 15 1", cnt[2], amx[2]); end
    checks++; if (!seen_c) begin errors++; $display("FAIL sat_pulse_c: got no step_up expected one"); end
    checks++; if (cnt[0] !== 4'd10) begin errors++; $display("FAIL wrap_cnt_a: got %0d expected 10", cnt[0]); end
    for (int k = 1; k <= 25; k++) begin down_in = (k <= 10); @(negedge clk); end
    checks++; if (cnt[1] !== 4'd15) begin errors++; $display("FAIL wrap_dn_b: got %0d expected 15", cnt[1]); end
    checks++; if (cnt[2] !== 4'd14) begin errors++; $display("FAIL sat_dn_c: got %0d expected 14", cnt[2]); end
    idle(5);
    $display("test_wrap done");
  endtask

  task automatic test_both();
    int both_k;
    do_clr();
    both_k = -1;
    for (int k = 1; k <= 25; k++) begin
      up_in = (k <= 10); down_in = (k <= 10);
      @(negedge clk);
      if (su[0] && sd[0] && both_k < 0) both_k = k;
    end
    checks++; if (both_k != 7) begin errors++; $display("FAIL both_pulse: got edge %0d expected 7", both_k); end
    checks++; if (cnt[0] !== 4'd8 || cnt[1] !== 4'd8) begin errors++; $display("FAIL both_hold: got a=%0d b=%0d expected 8 8", cnt[0], cnt[1]); end
    idle(5);
    $display("test_both done");
  endtask

  task automatic test_clr_repeat();
    do_clr();
    for (int k = 1; k <= 60; k++) begin
      up_in = (k <= 50); clr = (k == 41);
      @(negedge clk);
      if (k == 40) begin checks++; if (cnt[1] !== 4'd11) begin errors++; $display("FAIL clr_pre_b: got %0d expected 11", cnt[1]); end end
      if (k == 41) begin checks++; if (cnt[1] !== 4'd8) begin errors++; $display("FAIL clr_b: got %0d expected 8", cnt[1]); end end
      if (k == 46) begin checks++; if (su[1] !== 1'b1) begin errors++; $display("FAIL clr_next_pulse_b: got %b expected 1", su[1]); end end
      if (k == 47) begin checks++; if (cnt[1] !== 4'd9) begin errors++; $display("FAIL clr_next_cnt_b: got %0d expected 9", cnt[1]); end end
    end
    idle(5);
    $display("test_clr_repeat done");
  endtask

  task automatic test_reset_repeat();
    int first_a, first_b;
    do_clr();
    first_a = -1; first_b = -1;
    for (int k = 1; k <= 70; k++) begin
      up_in = (k <= 62);
      if (k == 41) begin
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (cnt[i] !== 4'd8 || su[i] !== 1'b0) begin errors++; $display("FAIL rst_mid[%0d]: got count=%0d up=%b expected 8 0", i, cnt[i], su[i]); end
        end
      end
      if (k == 44) rstn = 1'b1;
      @(negedge clk);
      if (k >= 44 && su[0] && first_a < 0) first_a = k;
      if (k >= 44 && su[1] && first_b < 0) first_b = k;
      if (k == 51) begin checks++; if (cnt[1] !== 4'd9) begin errors++; $display("FAIL rst_after_cnt_b: got %0d expected 9", cnt[1]); end end
    end
    checks++; if (first_a != 50) begin errors++; $display("FAIL rst_restep_a: got edge %0d expected 50", first_a); end
    checks++; if (first_b != 50) begin errors++; $display("FAIL rst_restep_b: got edge %0d expected 50", first_b); end
    idle(5);
    $display("test_reset_repeat done");
  endtask

  task automatic test_random();
    int up_left, dn_left;
    up_left = 0; dn_left = 0;
    for (int k = 0; k < 1500; k++) begin
      if (up_left == 0) begin
        up_in = 1'($urandom_range(0, 1));
        up_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
      end
      if (dn_left == 0) begin
        down_in = 1'($urandom_range(0, 1));
        dn_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
      end
      up_left--; dn_left--;
      clr = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    idle(40);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 4'(m_count[i])) begin errors++; $display("FAIL random_final[%0d]: got %0d expected %0d", i, cnt[i], m_count[i]); end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_repeat();
    test_wrap();
    test_both();
    test_clr_repeat();
    test_reset_repeat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
